// File: rtl/pipe_mon_pkg.sv
// Shared definitions for the pipeline event monitor: FSM encoding and trace-entry layout.
package pipe_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_e;

  localparam int TRACE_PC_W      = 32;
  localparam int TRACE_PC_LSB    = 0;
  localparam int TRACE_FLUSH_BIT = 32;
  localparam int TRACE_STALL_BIT = 33;
  localparam int TRACE_W         = 34;

  function automatic logic [TRACE_W-1:0] pack_entry(input logic stall, input logic flush,
                                                    input logic [TRACE_PC_W-1:0] pc);
    logic [TRACE_W-1:0] e;
    e = '0;
    e[TRACE_PC_LSB +: TRACE_PC_W] = pc;
    e[TRACE_FLUSH_BIT]            = flush;
    e[TRACE_STALL_BIT]            = stall;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace FIFO with registered occupancy, no fall-through, and a sticky overflow flag.
module trace_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             r_ovf;
  logic             w_pop_ok, w_push_ok;

  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign w_pop_ok  = pop_i && !empty_o;
  assign w_push_ok = push_i && (!full_o || w_pop_ok);
  assign data_o    = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign ovf_o     = r_ovf;

  always_ff @(posedge clk_i) begin
    if (w_push_ok && !clr_i) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (push_i && !w_push_ok) r_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_event_monitor.sv
// CPU pipeline event monitor: saturating run/stall/flush counters plus an optional
// event trace FIFO compiled in only when PIPE_MON_TRACE_EN is defined.
module pipe_event_monitor
  import pipe_mon_pkg::*;
#(
  parameter int CYCLE_LIMIT = 30,
  parameter int CNT_W       = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic [31:0]        pc_i,
  input  logic               lw_stall_i,
  input  logic               beq_flush_i,
  output logic [CNT_W-1:0]   cycle_o,
  output logic [CNT_W-1:0]   stall_o,
  output logic [CNT_W-1:0]   flush_o,
  output logic               done_o,
  output logic               trace_valid_o,
  input  logic               trace_ready_i,
  output logic [TRACE_W-1:0] trace_data_o,
  output logic               trace_ovf_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  mon_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cycle, r_stall, r_flush;
  logic [CNT_W-1:0] w_cycle_nxt;
  logic             w_run;

  // A cycle only counts while RUN is held by start_i; dropping start_i freezes counts.
  assign w_run       = (r_state == ST_RUN) && start_i;
  assign w_cycle_nxt = sat_inc(r_cycle);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start_i) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (!start_i)                              w_state_nxt = ST_IDLE;
          else if (w_cycle_nxt == CNT_W'(CYCLE_LIMIT)) w_state_nxt = ST_DONE;
        end
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cycle <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else if (clr_i) begin
      r_cycle <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else if (w_run) begin
      r_cycle <= w_cycle_nxt;
      if (lw_stall_i)  r_stall <= sat_inc(r_stall);
      if (beq_flush_i) r_flush <= sat_inc(r_flush);
    end
  end

  assign cycle_o = r_cycle;
  assign stall_o = r_stall;
  assign flush_o = r_flush;
  assign done_o  = (r_state == ST_DONE);

`ifdef PIPE_MON_TRACE_EN
  logic w_push, w_pop, w_empty, w_unused_full;

  assign w_push = w_run && (lw_stall_i || beq_flush_i);
  assign w_pop  = trace_valid_o && trace_ready_i;

  trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_trace_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (pack_entry(lw_stall_i, beq_flush_i, pc_i)),
    .data_o  (trace_data_o),
    .full_o  (w_unused_full),
    .empty_o (w_empty),
    .ovf_o   (trace_ovf_o)
  );

  assign trace_valid_o = !w_empty;
`else
  logic w_unused_ready;

  assign w_unused_ready = trace_ready_i;
  assign trace_valid_o  = 1'b0;
  assign trace_data_o   = '0;
  assign trace_ovf_o    = 1'b0;
`endif

endmodule

// File: doc/pipe_event_monitor.md
PIPE_EVENT_MONITOR -- requirements
Module: pipe_event_monitor

Interface
REQ-001 SHALL have parameter CYCLE_LIMIT, default 30, meaning the number of run cycles after which counting stops.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of every counter.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of trace entries (power of two).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start_i  input  1  CPU start; run enable.
REQ-007 SHALL have port clr_i  input  1  synchronous clear of counters, FIFO and state.
REQ-008 SHALL have port pc_i  input  32  current PC of the CPU.
REQ-009 SHALL have port lw_stall_i  input  1  load-use stall event from the CPU.
REQ-010 SHALL have port beq_flush_i  input  1  branch flush event from the CPU.
REQ-011 SHALL have port cycle_o  output  CNT_W  run-cycle count.
REQ-012 SHALL have port stall_o  output  CNT_W  stall count.
REQ-013 SHALL have port flush_o  output  CNT_W  flush count.
REQ-014 SHALL have port done_o  output  1  high once CYCLE_LIMIT is reached.
REQ-015 SHALL have port trace_valid_o  output  1  trace entry available.
REQ-016 SHALL have port trace_ready_i  input  1  consumer accepts the entry.
REQ-017 SHALL have port trace_data_o  output  34  {stall, flush, pc} of the head entry.
REQ-018 SHALL have port trace_ovf_o  output  1  sticky flag: a trace entry was dropped.

Function
REQ-019 SHALL implement the FSM IDLE, RUN, DONE: IDLE->RUN when start_i=1; RUN->IDLE when start_i=0, with counters holding; RUN->DONE on the cycle in which cycle_o reaches CYCLE_LIMIT; DONE->IDLE only on clr_i.
REQ-020 SHALL increment cycle_o by 1 on every RUN cycle; the count is visible one clock after the sampled edge.
REQ-021 SHALL increment stall_o on each RUN cycle with lw_stall_i=1, and flush_o on each RUN cycle with beq_flush_i=1; both may increment in the same cycle.
REQ-022 SHALL saturate every counter at all-ones with no wrap.
REQ-023 SHALL ignore events in IDLE and DONE; done_o equals (state==DONE).
REQ-024 SHALL push {lw_stall_i, beq_flush_i, pc_i} in a RUN cycle when either event is high.
REQ-025 SHALL use a valid/ready handshake for the trace port: a pop occurs when trace_valid_o && trace_ready_i; trace_data_o stays stable while valid is high and ready is low.
REQ-026 SHALL drop a push to a full FIFO without a simultaneous pop and set trace_ovf_o; a push and a pop on a full FIFO both succeed.
REQ-027 SHALL complete a push and a pop on an empty FIFO as a push only; valid rises the next cycle, with no fall-through.
REQ-028 SHALL give clr_i priority over all events: zero counters, empty FIFO, clear trace_ovf_o, go to IDLE.

Reset
REQ-029 SHALL, on rst_n_i low, immediately set state IDLE, all counters 0, done_o 0, trace_valid_o 0, trace_ovf_o 0, trace_data_o 0 and FIFO pointers 0, regardless of clk_i.
REQ-030 SHALL, on reset mid-RUN, discard in-flight counts and FIFO contents; after release, restart only when start_i=1.

Configuration
REQ-031 SHALL compile the trace FIFO and trace ports' logic when macro PIPE_MON_TRACE_EN is defined.
REQ-032 SHALL, without PIPE_MON_TRACE_EN, tie trace_valid_o, trace_data_o and trace_ovf_o to 0 and ignore trace_ready_i, keeping the ports present; the counters are unaffected.

Structure
REQ-033 SHALL place the FSM state encoding, the 34-bit trace-entry width and field offsets in shared package pipe_mon_pkg.
REQ-034 SHALL implement the FIFO as sub-module trace_fifo (params WIDTH, DEPTH; push, pop, full, empty, ovf).

Verification
REQ-035 SHALL cover: start_i=1 for 40 cycles with no events -> cycle_o=30, done_o=1, counters then frozen.
REQ-036 SHALL cover: lw_stall_i pulsed on 3 cycles and beq_flush_i on 2 cycles, one cycle both, during RUN -> stall_o=3, flush_o=2, 4 FIFO entries in order with correct bits and PC values.
REQ-037 SHALL cover: trace_ready_i=0 and 10 events -> first 8 kept, trace_ovf_o=1; then ready=1 -> 8 pops, valid falls.
REQ-038 SHALL cover: FIFO full, simultaneous event and ready=1 -> count stays 8, no overflow.
REQ-039 SHALL cover: rst_n_i asserted mid-cycle at cycle 12 of RUN -> all outputs 0 before next edge; start_i deasserted at cycle 5 -> cycle_o holds 5.
REQ-040 SHALL cover: PIPE_MON_TRACE_EN undefined, same events as REQ-036 -> counters identical, trace_valid_o stays 0.
